// File: rtl/dmem_wbuf_pkg.sv
// dmem_wbuf_pkg: shared types and constants for the posted-store write buffer.
//   - wbuf_state_e : memory-port FSM states
//   - wbuf_entry_t : one buffered store {word address, data}
//   - word_to_byte : rebuilds a word-aligned byte address from a word address
package dmem_wbuf_pkg;

  localparam int WBUF_DEPTH  = 4;
  localparam int WBUF_DATA_W = 32;
  localparam int WBUF_ADDR_W = 32;
  localparam int WBUF_WORD_W = WBUF_ADDR_W - 2;
  localparam int PTR_W       = $clog2(WBUF_DEPTH);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_DONE = 2'd3
  } wbuf_state_e;

  typedef struct packed {
    logic [WBUF_WORD_W-1:0] word_addr;
    logic [WBUF_DATA_W-1:0] data;
  } wbuf_entry_t;

  function automatic logic [WBUF_ADDR_W-1:0] word_to_byte(input logic [WBUF_WORD_W-1:0] word_addr);
    return {word_addr, 2'b00};
  endfunction

endpackage

// File: rtl/dmem_wbuf_checker.sv
// dmem_wbuf_checker: simulation-only protocol checks for dmem_write_buffer.
//   clk, reset       : clock and active-low async reset
//   cpu_wr, cpu_rd   : MEM-stage store/load strobes
//   mem_req, mem_ack : memory handshake
module dmem_wbuf_checker (
  input logic clk,
  input logic reset,
  input logic cpu_wr,
  input logic cpu_rd,
  input logic mem_req,
  input logic mem_ack
);

  // A MEM stage cannot issue a store and a load in the same instruction.
  a_no_wr_rd : assert property (@(posedge clk) disable iff (!reset) !(cpu_wr && cpu_rd))
    else $error("dmem_write_buffer: store and load asserted together; store taken");

  // The request must drop on the edge after its acknowledge.
  a_req_drop : assert property (@(posedge clk) disable iff (!reset) (mem_req && mem_ack) |=> !mem_req)
    else $error("dmem_write_buffer: mem_req still high after mem_ack");

endmodule

// File: rtl/dmem_wbuf_match.sv
// wbuf_match: associative lookup of a load word address across all buffer slots.
//   valid     : per-slot occupancy
//   entries   : slot contents
//   wr_ptr    : next slot to be written; slot wr_ptr+k is older for smaller k
//   word_addr : load word address
//   hit       : some valid slot matches
//   hit_data  : data of the youngest matching slot
module wbuf_match
  import dmem_wbuf_pkg::*;
#(
  parameter int DEPTH = WBUF_DEPTH,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0]                valid,
  input  wbuf_entry_t [DEPTH-1:0]         entries,
  input  logic [IDX_W-1:0]                wr_ptr,
  input  logic [WBUF_WORD_W-1:0]          word_addr,
  output logic                            hit,
  output logic [WBUF_DATA_W-1:0]          hit_data
);

  logic                   hit_s;
  logic [WBUF_DATA_W-1:0] data_s;

  // Walk slots oldest-to-youngest (starting at wr_ptr) so the last match, the youngest store, wins.
  always_comb begin
    logic [IDX_W-1:0] idx_s;
    hit_s  = 1'b0;
    data_s = {WBUF_DATA_W{1'b0}};
    idx_s  = {IDX_W{1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx_s = wr_ptr + IDX_W'(k);
      if (valid[idx_s] && (entries[idx_s].word_addr == word_addr)) begin
        hit_s  = 1'b1;
        data_s = entries[idx_s].data;
      end else begin
        hit_s  = hit_s;
        data_s = data_s;
      end
    end
  end

  assign hit      = hit_s;
  assign hit_data = data_s;

endmodule

// File: rtl/dmem_write_buffer.sv
// dmem_write_buffer: posted-store buffer between MEM stage and a variable-latency data memory.
//   Stores enter a FIFO in zero stall cycles and drain in the background; loads forward from the
//   youngest matching buffered store, otherwise go to memory ahead of pending drains.
//   clk, reset (async active-low)
//   cpu_wr/cpu_rd/cpu_addr/cpu_wdata in, cpu_rdata/cpu_stall out : pipeline side
//   mem_req/mem_we/mem_addr/mem_wdata out (registered), mem_ack/mem_rdata in : memory side
//   buf_empty : no buffered stores
// Entry layout comes from dmem_wbuf_pkg; DATA_W/ADDR_W must stay at the package widths.
module dmem_write_buffer
  import dmem_wbuf_pkg::*;
#(
  parameter int DEPTH  = WBUF_DEPTH,
  parameter int DATA_W = WBUF_DATA_W,
  parameter int ADDR_W = WBUF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_wr,
  input  logic              cpu_rd,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              buf_empty
);

  localparam int               IDX_W    = $clog2(DEPTH);
  localparam logic [IDX_W:0]   FULL_CNT = (IDX_W+1)'(DEPTH);
  localparam logic [IDX_W:0]   CNT_ONE  = (IDX_W+1)'(1);
  localparam logic [IDX_W-1:0] PTR_ONE  = IDX_W'(1);

  wbuf_state_e            state_r, next_state_s;
  wbuf_entry_t [DEPTH-1:0] buf_r;
  logic [IDX_W-1:0]       wr_ptr_r, rd_ptr_r;
  logic [IDX_W:0]         count_r;
  logic [DEPTH-1:0]       valid_s;
  logic                   hit_s;
  logic [DATA_W-1:0]      hit_data_s;
  logic                   push_s, pop_s, issue_rd_s, issue_wr_s, capture_s, load_miss_s;
  logic                   stall_s;
  logic [DATA_W-1:0]      rdata_s, rd_hold_r;
  logic                   mem_req_r, mem_we_r;
  logic [ADDR_W-1:0]      mem_addr_r;
  logic [DATA_W-1:0]      mem_wdata_r;
  logic                   addr_lsb_unused_s;

  assign addr_lsb_unused_s = ^cpu_addr[1:0];

  // Slot i holds a live store when its distance from the head is below the count.
  always_comb begin
    logic [IDX_W-1:0] offs_s;
    valid_s = {DEPTH{1'b0}};
    offs_s  = {IDX_W{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      offs_s     = IDX_W'(i) - rd_ptr_r;
      valid_s[i] = ({1'b0, offs_s} < count_r);
    end
  end

  wbuf_match #(.DEPTH(DEPTH), .IDX_W(IDX_W)) u_match (
    .valid     (valid_s),
    .entries   (buf_r),
    .wr_ptr    (wr_ptr_r),
    .word_addr (cpu_addr[ADDR_W-1:2]),
    .hit       (hit_s),
    .hit_data  (hit_data_s)
  );

  // Full is judged on the registered count, so a store waits one cycle past the freeing ack.
  assign push_s      = cpu_wr && (count_r != FULL_CNT);
  assign load_miss_s = cpu_rd && !cpu_wr && !hit_s;

  // Pipeline-side stall and load data; RD_DONE presents the captured miss data for one cycle.
  always_comb begin
    stall_s = 1'b0;
    rdata_s = {DATA_W{1'b0}};
    if (cpu_wr) begin
      stall_s = (count_r == FULL_CNT);
    end else if (cpu_rd) begin
      if (state_r == RD_DONE) begin
        rdata_s = rd_hold_r;
      end else if (hit_s) begin
        rdata_s = hit_data_s;
      end else begin
        stall_s = 1'b1;
      end
    end else begin
      stall_s = 1'b0;
    end
  end

  // FSM next state and transaction strobes; loads take priority over draining in IDLE.
  always_comb begin
    next_state_s = state_r;
    issue_rd_s   = 1'b0;
    issue_wr_s   = 1'b0;
    pop_s        = 1'b0;
    capture_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (load_miss_s) begin
          next_state_s = RD_REQ;
          issue_rd_s   = 1'b1;
        end else if (count_r != {(IDX_W+1){1'b0}}) begin
          next_state_s = WR_REQ;
          issue_wr_s   = 1'b1;
        end else begin
          next_state_s = IDLE;
        end
      end
      WR_REQ: begin
        if (mem_ack) begin
          pop_s        = 1'b1;
          next_state_s = IDLE;
        end else begin
          next_state_s = WR_REQ;
        end
      end
      RD_REQ: begin
        if (mem_ack) begin
          capture_s    = 1'b1;
          next_state_s = RD_DONE;
        end else begin
          next_state_s = RD_REQ;
        end
      end
      RD_DONE: next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // FIFO pointers, occupancy count and storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= {IDX_W{1'b0}};
      rd_ptr_r <= {IDX_W{1'b0}};
      count_r  <= {(IDX_W+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        buf_r[i] <= {($bits(wbuf_entry_t)){1'b0}};
      end
    end else begin
      if (push_s) begin
        buf_r[wr_ptr_r].word_addr <= cpu_addr[ADDR_W-1:2];
        buf_r[wr_ptr_r].data      <= cpu_wdata;
        wr_ptr_r                  <= wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
    end
  end

  // Registered memory port and miss-data holding register; the request drops on the ack edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_req_r   <= 1'b0;
      mem_we_r    <= 1'b0;
      mem_addr_r  <= {ADDR_W{1'b0}};
      mem_wdata_r <= {DATA_W{1'b0}};
      rd_hold_r   <= {DATA_W{1'b0}};
    end else begin
      if (issue_rd_s) begin
        mem_req_r  <= 1'b1;
        mem_we_r   <= 1'b0;
        mem_addr_r <= {cpu_addr[ADDR_W-1:2], 2'b00};
      end else if (issue_wr_s) begin
        mem_req_r   <= 1'b1;
        mem_we_r    <= 1'b1;
        mem_addr_r  <= word_to_byte(buf_r[rd_ptr_r].word_addr);
        mem_wdata_r <= buf_r[rd_ptr_r].data;
      end else if (pop_s || capture_s) begin
        mem_req_r <= 1'b0;
      end else begin
        mem_req_r <= mem_req_r;
      end
      if (capture_s) begin
        rd_hold_r <= mem_rdata;
      end else begin
        rd_hold_r <= rd_hold_r;
      end
    end
  end

  dmem_wbuf_checker u_chk (
    .clk     (clk),
    .reset   (reset),
    .cpu_wr  (cpu_wr),
    .cpu_rd  (cpu_rd),
    .mem_req (mem_req_r),
    .mem_ack (mem_ack)
  );

  // Stall is forced low while reset is asserted so the pipeline sees a quiet interface.
  assign cpu_stall = stall_s & reset;
  assign cpu_rdata = rdata_s;
  assign mem_req   = mem_req_r;
  assign mem_we    = mem_we_r;
  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign buf_empty = (count_r == {(IDX_W+1){1'b0}});

endmodule

// File: tb/tb_dmem_write_buffer.sv
// tb_dmem_write_buffer: self-checking bench for dmem_write_buffer.
// A memory responder acks requests after a programmable delay; expected writes are queued
// when stores are driven and popped when the DUT presents each write to memory.
module tb_dmem_write_buffer;

  logic        clk, reset;
  logic        cpu_wr, cpu_rd;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_stall;
  logic        mem_req, mem_we, mem_ack;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        buf_empty;

  int tests_run    = 0;
  int tests_failed = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } wr_exp_t;
  wr_exp_t exp_wr_q[$];

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        exp_stall;
    logic [31:0] exp_rdata;
  } vec_t;
  vec_t tbl [10];

  int          ack_delay     = 3;
  int          wait_cnt      = 0;
  int          wr_ack_cnt    = 0;
  int          rd_ack_cnt    = 0;
  int          wr_acks_at_rd = 0;
  logic [31:0] exp_rd_addr   = 32'h0;
  logic [31:0] rd_data_next  = 32'h0;

  dmem_write_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .cpu_wr    (cpu_wr),
    .cpu_rd    (cpu_rd),
    .cpu_addr  (cpu_addr),
    .cpu_wdata (cpu_wdata),
    .cpu_rdata (cpu_rdata),
    .cpu_stall (cpu_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .buf_empty (buf_empty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
    end
  endtask

  // Memory responder: acks the outstanding request ack_delay cycles after it appears.
  initial begin
    wr_exp_t e;
    mem_ack   = 1'b0;
    mem_rdata = 32'h0;
    forever begin
      @(posedge clk); #1;
      if (!reset) begin
        mem_ack  = 1'b0;
        wait_cnt = 0;
      end else if (mem_ack) begin
        mem_ack = 1'b0;
      end else if (mem_req) begin
        if (wait_cnt >= ack_delay) begin
          mem_ack  = 1'b1;
          wait_cnt = 0;
          if (mem_we) begin
            wr_ack_cnt++;
            if (exp_wr_q.size() == 0) begin
              tests_run++;
              tests_failed++;
              $display("FAIL wr_unexpected: got write 0x%08h to 0x%08h, expected none", mem_wdata, mem_addr);
            end else begin
              e = exp_wr_q.pop_front();
              check("wr_addr", mem_addr, e.addr);
              check("wr_data", mem_wdata, e.data);
            end
          end else begin
            rd_ack_cnt++;
            wr_acks_at_rd = wr_ack_cnt;
            check("rd_addr", mem_addr, exp_rd_addr);
            mem_rdata = rd_data_next;
          end
        end else begin
          wait_cnt++;
        end
      end
    end
  end

  task automatic store(input logic [31:0] a, input logic [31:0] d, output int stalls);
    wr_exp_t e;
    cpu_wr = 1'b1; cpu_rd = 1'b0; cpu_addr = a; cpu_wdata = d;
    stalls = 0;
    @(negedge clk);
    while (cpu_stall && stalls < 300) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 300) begin
      tests_run++; tests_failed++;
      $display("FAIL store_timeout: got stall after %0d cycles, expected release", stalls);
    end
    e.addr = {a[31:2], 2'b00};
    e.data = d;
    exp_wr_q.push_back(e);
    @(posedge clk); #1;
    cpu_wr = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, output logic [31:0] data, output int stalls);
    cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = a;
    stalls = 0;
    @(negedge clk);
    while (cpu_stall && stalls < 300) begin
      stalls++;
      @(negedge clk);
    end
    if (stalls >= 300) begin
      tests_run++; tests_failed++;
      $display("FAIL load_timeout: got stall after %0d cycles, expected release", stalls);
    end
    data = cpu_rdata;
    @(posedge clk); #1;
    cpu_rd = 1'b0;
  endtask

  task automatic wait_drain(input string nm);
    int n = 0;
    @(negedge clk);
    while (!(buf_empty && !mem_req) && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_empty"}, {31'd0, buf_empty}, 32'd1);
    check({nm, "_noreq"}, {31'd0, mem_req}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion, expected $finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int          st;
    int          before_wr, before_rd, rd_seen;
    logic [31:0] d;

    tbl[0] = '{1'b1, 1'b0, 32'h20, 32'h0000AAAA, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 32'h20, 32'h0000BBBB, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b1, 32'h22, 32'h0,        1'b0, 32'h0000BBBB};
    tbl[3] = '{1'b1, 1'b0, 32'h24, 32'h00001111, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b1, 32'h24, 32'h0,        1'b0, 32'h00001111};
    tbl[5] = '{1'b0, 1'b1, 32'h20, 32'h0,        1'b0, 32'h0000BBBB};
    tbl[6] = '{1'b1, 1'b0, 32'h28, 32'h00002222, 1'b0, 32'h0};
    tbl[7] = '{1'b0, 1'b1, 32'h2B, 32'h0,        1'b0, 32'h00002222};
    tbl[8] = '{1'b0, 1'b1, 32'h21, 32'h0,        1'b0, 32'h0000BBBB};
    tbl[9] = '{1'b0, 1'b0, 32'h0,  32'h0,        1'b0, 32'h0};

    cpu_wr = 1'b0; cpu_rd = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
    reset = 1'b1;
    #1 reset = 1'b0;
    #2;
    check("rst_mem_req",   {31'd0, mem_req},   32'd0);
    check("rst_mem_we",    {31'd0, mem_we},    32'd0);
    check("rst_mem_addr",  mem_addr,           32'h0);
    check("rst_mem_wdata", mem_wdata,          32'h0);
    check("rst_cpu_rdata", cpu_rdata,          32'h0);
    check("rst_cpu_stall", {31'd0, cpu_stall}, 32'd0);
    check("rst_buf_empty", {31'd0, buf_empty}, 32'd1);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Four posted stores drain in order with no stall.
    ack_delay = 3;
    before_wr = wr_ack_cnt;
    for (int i = 0; i < 4; i++) begin
      store(32'h10 + 32'(4 * i), 32'hD000_0000 + 32'(i), st);
      check($sformatf("t1_stall%0d", i), st, 32'd0);
    end
    wait_drain("t1");
    check("t1_writes", wr_ack_cnt - before_wr, 32'd4);

    // Fifth store against a full buffer waits until the cycle after the first pop.
    before_wr = wr_ack_cnt;
    for (int i = 0; i < 4; i++) begin
      store(32'h30 + 32'(4 * i), 32'hE000_0000 + 32'(i), st);
    end
    store(32'h44, 32'hE000_0004, st);
    check("t2_full_stalls", st, 32'd2);
    wait_drain("t2");
    check("t2_writes", wr_ack_cnt - before_wr, 32'd5);

    // Table: stores and forwarded loads applied one per cycle.
    ack_delay = 12;
    before_rd = rd_ack_cnt;
    rd_seen   = 0;
    for (int i = 0; i < 10; i++) begin
      cpu_wr = tbl[i].wr; cpu_rd = tbl[i].rd; cpu_addr = tbl[i].addr; cpu_wdata = tbl[i].wdata;
      if (tbl[i].wr) begin
        exp_wr_q.push_back('{addr: {tbl[i].addr[31:2], 2'b00}, data: tbl[i].wdata});
      end
      @(negedge clk);
      check($sformatf("vec%0d_stall", i), {31'd0, cpu_stall}, {31'd0, tbl[i].exp_stall});
      check($sformatf("vec%0d_rdata", i), cpu_rdata, tbl[i].exp_rdata);
      if (mem_req && !mem_we) rd_seen++;
      @(posedge clk); #1;
    end
    cpu_wr = 1'b0; cpu_rd = 1'b0;
    wait_drain("t3");
    check("t3_no_read_req", rd_seen, 32'd0);
    check("t3_no_read_ack", rd_ack_cnt - before_rd, 32'd0);

    // Load miss on an empty buffer with an immediate ack: two stall cycles.
    ack_delay    = 0;
    rd_data_next = 32'h0000_1234;
    exp_rd_addr  = 32'h40;
    before_rd    = rd_ack_cnt;
    load(32'h40, d, st);
    check("t4_stalls", st, 32'd2);
    check("t4_rdata", d, 32'h0000_1234);
    check("t4_reads", rd_ack_cnt - before_rd, 32'd1);

    // Load miss while a drain is in flight: write finishes first, then the read.
    ack_delay    = 4;
    rd_data_next = 32'hCAFE_F00D;
    exp_rd_addr  = 32'h60;
    before_wr    = wr_ack_cnt;
    store(32'h50, 32'h5000_0000, st);
    store(32'h54, 32'h5000_0001, st);
    store(32'h58, 32'h5000_0002, st);
    load(32'h60, d, st);
    check("t5_rdata", d, 32'hCAFE_F00D);
    check("t5_wr_before_rd", wr_acks_at_rd - before_wr, 32'd1);
    check("t5_min_stall", {31'd0, st >= 6}, 32'd1);
    check("t5_entries_left", {31'd0, buf_empty}, 32'd0);
    wait_drain("t5");
    check("t5_writes", wr_ack_cnt - before_wr, 32'd3);

    // Asynchronous reset during an outstanding write with three entries buffered.
    ack_delay = 20;
    store(32'h70, 32'h7000_0000, st);
    store(32'h74, 32'h7000_0001, st);
    store(32'h78, 32'h7000_0002, st);
    @(negedge clk);
    check("t6_pre_req", {31'd0, mem_req}, 32'd1);
    check("t6_pre_empty", {31'd0, buf_empty}, 32'd0);
    #2 reset = 1'b0;
    #1;
    check("t6_req", {31'd0, mem_req}, 32'd0);
    check("t6_we", {31'd0, mem_we}, 32'd0);
    check("t6_empty", {31'd0, buf_empty}, 32'd1);
    check("t6_stall", {31'd0, cpu_stall}, 32'd0);
    exp_wr_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;

    // Buffer works again after reset.
    ack_delay = 1;
    before_wr = wr_ack_cnt;
    store(32'h80, 32'h8000_0080, st);
    check("t7_stall", st, 32'd0);
    wait_drain("t7");
    check("t7_writes", wr_ack_cnt - before_wr, 32'd1);
    check("final_queue", exp_wr_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
